// File: rtl/brdec_pkg.sv
// Shared constants for the fetch-packet branch predecoder: RV32I control-transfer
// encodings, redirect type codes and RAS actions.
package brdec_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [2:0]  F3_JALR   = 3'b000;
  localparam logic [2:0]  F3_PRIV   = 3'b000;
  localparam logic [2:0]  F3_RSV0   = 3'b010;
  localparam logic [2:0]  F3_RSV1   = 3'b011;
  localparam logic [11:0] F12_URET  = 12'h002;

  typedef enum logic [1:0] {
    BR_COND, BR_INDIR_PC, BR_INDIR_RS, BR_INDIR_RAS
  } br_typ_e;

  typedef enum logic [1:0] {
    RAS_NOACT, RAS_PUSHPC, RAS_POPPC, RAS_POPPUSH
  } ras_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_WAIT_RS1, ST_RESP
  } state_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/brdec_lane.sv
// Combinational predecode of one instruction slot: class, prediction, PC-relative
// target and the RAS action the lane would cause if selected.
module brdec_lane
  import brdec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            vld,
  output logic            is_cti,
  output logic            taken,
  output br_typ_e         typ,
  output logic [XLEN-1:0] tar,
  output ras_ctl_e        ras_ctl,
  output logic [4:0]      rs1,
  output logic [XLEN-1:0] imm_i
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic [XLEN-1:0] off_b, off_j;
  logic            is_br, is_jal, is_jalr, is_uret, is_ret;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign imm_i  = XLEN'($signed(inst[31:20]));
  assign off_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign off_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  assign is_br   = vld && opcode == OP_BRANCH && f3 != F3_RSV0 && f3 != F3_RSV1;
  assign is_jal  = vld && opcode == OP_JAL;
  assign is_jalr = vld && opcode == OP_JALR && f3 == F3_JALR;
  assign is_uret = vld && opcode == OP_SYSTEM && f3 == F3_PRIV && inst[31:20] == F12_URET;
  // A return reads a link register that it does not also overwrite.
  assign is_ret  = (is_jalr && is_link(rs1) && rd != rs1) || is_uret;

  always_comb begin
    is_cti  = is_br | is_jal | is_jalr | is_uret;
    taken   = (is_br & inst[31]) | is_jal | is_jalr | is_uret;
    typ     = BR_COND;
    tar     = pc + off_b;
    ras_ctl = RAS_NOACT;
    if (is_jal) begin
      typ = BR_INDIR_PC;
      tar = pc + off_j;
      if (is_link(rd)) ras_ctl = RAS_PUSHPC;
    end else if (is_ret) begin
      typ     = BR_INDIR_RAS;
      tar     = '0;
      ras_ctl = (is_jalr && is_link(rd)) ? RAS_POPPUSH : RAS_POPPC;
    end else if (is_jalr) begin
      typ = BR_INDIR_RS;
      tar = '0;
      if (is_link(rd)) ras_ctl = RAS_PUSHPC;
    end
  end

endmodule

// File: rtl/brdec_bank.sv
// Fetch-packet branch predecoder: picks the first predicted-taken lane, fetches
// JALR rs1 when needed, owns the return address stack and emits one redirect per packet.
module brdec_bank
  import brdec_pkg::*;
#(
  parameter int NWAY      = 8,
  parameter int XLEN      = 64,
  parameter int RAS_DEPTH = 8,
  parameter int PC_STEP   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       pkt_vld_i,
  output logic                       pkt_rdy_o,
  input  logic [XLEN-1:0]            pkt_pc_i,
  input  logic [NWAY*32-1:0]         pkt_inst_i,
  input  logic [NWAY-1:0]            pkt_mask_i,
  output logic                       rs1_req_o,
  output logic [4:0]                 rs1_idx_o,
  input  logic                       rs1_ack_i,
  input  logic [XLEN-1:0]            rs1_data_i,
  output logic                       redir_vld_o,
  output logic                       redir_taken_o,
  output logic [$clog2(NWAY)-1:0]    redir_way_o,
  output logic [1:0]                 redir_typ_o,
  output logic [XLEN-1:0]            redir_tar_o,
  output logic [NWAY-1:0]            br_mask_o,
  output logic [1:0]                 dbg_state_o,
  output logic [$clog2(RAS_DEPTH):0] dbg_ras_cnt_o
);

  localparam int WW = $clog2(NWAY);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a packet transfers on a rising edge where pkt_vld_i & pkt_rdy_o;
  // rs1 transfers on the first edge with rs1_req_o & rs1_ack_i, and rs1_idx_o is
  // stable while rs1_req_o is high.
  state_e          state;
  logic [XLEN-1:0] lane_pc   [NWAY];
  logic [XLEN-1:0] lane_tar  [NWAY];
  logic [XLEN-1:0] lane_imm  [NWAY];
  br_typ_e         lane_typ  [NWAY];
  ras_ctl_e        lane_ras  [NWAY];
  logic [4:0]      lane_rs1  [NWAY];
  logic [NWAY-1:0] lane_cti, lane_taken;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr, ptr_inc, ptr_dec;
  logic [CW-1:0]   ras_cnt;
  logic [XLEN-1:0] ras_top;

  logic            sel_found;
  logic [WW-1:0]   sel_way;
  logic [XLEN-1:0] sel_tar;
  ras_ctl_e        ras_op;
  logic [XLEN-1:0] push_addr, rs_imm;

  for (genvar g = 0; g < NWAY; g++) begin : g_lane
    assign lane_pc[g] = pkt_pc_i + XLEN'(g * PC_STEP);
    brdec_lane #(.XLEN(XLEN)) u_lane (
      .inst    (pkt_inst_i[32*g +: 32]),
      .pc      (lane_pc[g]),
      .vld     (pkt_mask_i[g]),
      .is_cti  (lane_cti[g]),
      .taken   (lane_taken[g]),
      .typ     (lane_typ[g]),
      .tar     (lane_tar[g]),
      .ras_ctl (lane_ras[g]),
      .rs1     (lane_rs1[g]),
      .imm_i   (lane_imm[g])
    );
  end

  assign ras_top       = (ras_cnt != '0) ? ras_mem[ras_ptr] : '0;
  assign ptr_inc       = ras_ptr + 1'b1;
  assign ptr_dec       = ras_ptr - 1'b1;
  assign pkt_rdy_o     = (state == ST_IDLE) && !flush_i;
  assign dbg_state_o   = state;
  assign dbg_ras_cnt_o = ras_cnt;

  always_comb begin
    sel_found = 1'b0;
    sel_way   = '0;
    for (int i = NWAY - 1; i >= 0; i--) begin
      if (lane_taken[i]) begin
        sel_found = 1'b1;
        sel_way   = WW'(i);
      end
    end
    if (!sel_found)                          sel_tar = pkt_pc_i + XLEN'(NWAY * PC_STEP);
    else if (lane_typ[sel_way] == BR_INDIR_RAS) sel_tar = ras_top;
    else                                     sel_tar = lane_tar[sel_way];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      rs1_req_o     <= 1'b0;
      rs1_idx_o     <= '0;
      redir_vld_o   <= 1'b0;
      redir_taken_o <= 1'b0;
      redir_way_o   <= '0;
      redir_typ_o   <= '0;
      redir_tar_o   <= '0;
      br_mask_o     <= '0;
      ras_op        <= RAS_NOACT;
      push_addr     <= '0;
      rs_imm        <= '0;
      ras_ptr       <= '0;
      ras_cnt       <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (flush_i) begin
      state       <= ST_IDLE;
      rs1_req_o   <= 1'b0;
      redir_vld_o <= 1'b0;
    end else begin
      redir_vld_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pkt_vld_i) begin
            br_mask_o     <= lane_cti;
            redir_taken_o <= sel_found;
            redir_way_o   <= sel_way;
            redir_typ_o   <= sel_found ? lane_typ[sel_way] : BR_COND;
            redir_tar_o   <= sel_tar;
            ras_op        <= sel_found ? lane_ras[sel_way] : RAS_NOACT;
            push_addr     <= lane_pc[sel_way] + XLEN'(PC_STEP);
            rs_imm        <= lane_imm[sel_way];
            if (sel_found && lane_typ[sel_way] == BR_INDIR_RS) begin
              state     <= ST_WAIT_RS1;
              rs1_req_o <= 1'b1;
              rs1_idx_o <= lane_rs1[sel_way];
            end else begin
              state       <= ST_RESP;
              redir_vld_o <= 1'b1;
            end
          end
        end
        ST_WAIT_RS1: begin
          if (rs1_ack_i) begin
            rs1_req_o   <= 1'b0;
            redir_tar_o <= (rs1_data_i + rs_imm) & ~XLEN'(1);
            redir_vld_o <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          // Full stack wraps over its oldest entry; an empty pop is a no-op.
          case (ras_op)
            RAS_PUSHPC: begin
              ras_ptr          <= ptr_inc;
              ras_mem[ptr_inc] <= push_addr;
              if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
            end
            RAS_POPPC: begin
              if (ras_cnt != '0) begin
                ras_ptr <= ptr_dec;
                ras_cnt <= ras_cnt - 1'b1;
              end
            end
            RAS_POPPUSH: begin
              if (ras_cnt != '0) begin
                ras_mem[ras_ptr] <= push_addr;
              end else begin
                ras_ptr          <= ptr_inc;
                ras_mem[ptr_inc] <= push_addr;
                ras_cnt          <= ras_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brdec_bank.sv
// Bench for brdec_bank: directed vector table, hand sequences for RAS wrap, flush
// and reset, then random packets against a queue-based reference model.
module tb_brdec_bank;

  localparam int NWAY      = 8;
  localparam int XLEN      = 64;
  localparam int RAS_DEPTH = 8;
  localparam int PC_STEP   = 4;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] URET = 32'h00200073;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              pkt_vld_i = 1'b0;
  logic              pkt_rdy_o;
  logic [63:0]       pkt_pc_i = '0;
  logic [255:0]      pkt_inst_i = '0;
  logic [7:0]        pkt_mask_i = '0;
  logic              rs1_req_o;
  logic [4:0]        rs1_idx_o;
  logic              rs1_ack_i = 1'b0;
  logic [63:0]       rs1_data_i = '0;
  logic              redir_vld_o, redir_taken_o;
  logic [2:0]        redir_way_o;
  logic [1:0]        redir_typ_o;
  logic [63:0]       redir_tar_o;
  logic [7:0]        br_mask_o;
  logic [1:0]        dbg_state_o;
  logic [3:0]        dbg_ras_cnt_o;

  brdec_bank #(.NWAY(NWAY), .XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH), .PC_STEP(PC_STEP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .pkt_vld_i(pkt_vld_i), .pkt_rdy_o(pkt_rdy_o), .pkt_pc_i(pkt_pc_i),
    .pkt_inst_i(pkt_inst_i), .pkt_mask_i(pkt_mask_i),
    .rs1_req_o(rs1_req_o), .rs1_idx_o(rs1_idx_o), .rs1_ack_i(rs1_ack_i), .rs1_data_i(rs1_data_i),
    .redir_vld_o(redir_vld_o), .redir_taken_o(redir_taken_o), .redir_way_o(redir_way_o),
    .redir_typ_o(redir_typ_o), .redir_tar_o(redir_tar_o), .br_mask_o(br_mask_o),
    .dbg_state_o(dbg_state_o), .dbg_ras_cnt_o(dbg_ras_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // instruction encoders
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] o);
    return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] o);
    return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  // reference model: RAS as a bounded queue, newest entry at the back
  logic [63:0] ras_q[$];

  function automatic logic [63:0] ras_peek();
    return (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : 64'd0;
  endfunction
  function automatic void ras_push(input logic [63:0] a);
    ras_q.push_back(a);
    if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
  endfunction
  function automatic void ras_pop();
    if (ras_q.size() > 0) void'(ras_q.pop_back());
  endfunction
  function automatic bit link(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction

  logic        m_taken, m_req;
  logic [2:0]  m_way;
  logic [1:0]  m_typ;
  logic [63:0] m_tar;
  logic [7:0]  m_bmask;
  logic [4:0]  m_idx;

  task automatic model_pkt(input logic [63:0] pc, input logic [255:0] inst,
                           input logic [7:0] mask, input logic [63:0] data);
    int cls, sel_cls;
    logic [31:0] ins, sel_ins;
    logic [63:0] lpc, sel_pc, boff, joff, iimm;
    m_taken = 0; m_req = 0; m_way = 0; m_typ = 0; m_bmask = 0; m_idx = 0;
    sel_cls = 0; sel_ins = 0; sel_pc = 0;
    for (int i = 0; i < NWAY; i++) begin
      ins = inst[32*i +: 32];
      lpc = pc + 64'(i * PC_STEP);
      cls = 0; // 1 branch, 2 jal, 3 return, 4 other jalr
      if (mask[i]) begin
        if (ins[6:0] == 7'b1100011 && ins[14:12] != 3'd2 && ins[14:12] != 3'd3) cls = 1;
        else if (ins[6:0] == 7'b1101111) cls = 2;
        else if (ins[6:0] == 7'b1100111 && ins[14:12] == 3'd0)
          cls = (link(ins[19:15]) && ins[11:7] != ins[19:15]) ? 3 : 4;
        else if (ins[6:0] == 7'b1110011 && ins[14:12] == 3'd0 && ins[31:20] == 12'h002) cls = 3;
      end
      if (cls != 0) m_bmask[i] = 1'b1;
      if (!m_taken && (cls >= 2 || (cls == 1 && ins[31]))) begin
        m_taken = 1; m_way = 3'(i); sel_cls = cls; sel_ins = ins; sel_pc = lpc;
      end
    end
    boff = {{52{sel_ins[31]}}, sel_ins[7], sel_ins[30:25], sel_ins[11:8], 1'b0};
    joff = {{44{sel_ins[31]}}, sel_ins[19:12], sel_ins[20], sel_ins[30:21], 1'b0};
    iimm = {{52{sel_ins[31]}}, sel_ins[31:20]};
    m_tar = pc + 64'(NWAY * PC_STEP);
    case (sel_cls)
      1: begin m_typ = 0; m_tar = sel_pc + boff; end
      2: begin
        m_typ = 1; m_tar = sel_pc + joff;
        if (link(sel_ins[11:7])) ras_push(sel_pc + 64'(PC_STEP));
      end
      3: begin
        m_typ = 3; m_tar = ras_peek();
        ras_pop();
        if (sel_ins[6:0] == 7'b1100111 && link(sel_ins[11:7])) ras_push(sel_pc + 64'(PC_STEP));
      end
      4: begin
        m_typ = 2; m_req = 1; m_idx = sel_ins[19:15];
        m_tar = (data + iimm) & ~64'd1;
        if (link(sel_ins[11:7])) ras_push(sel_pc + 64'(PC_STEP));
      end
      default: ;
    endcase
  endtask

  // driver: offer one packet, service rs1, capture the redirect
  logic        g_vld, g_vld_next, g_taken, g_req, g_held;
  logic [2:0]  g_way;
  logic [1:0]  g_typ;
  logic [63:0] g_tar;
  logic [7:0]  g_bmask;
  logic [4:0]  g_idx;
  int          g_cnt, g_lat;

  task automatic run_pkt(input logic [63:0] pc, input logic [255:0] inst, input logic [7:0] mask,
                         input logic [63:0] data, input int dly);
    int w;
    @(negedge clk_i);
    pkt_pc_i = pc; pkt_inst_i = inst; pkt_mask_i = mask; pkt_vld_i = 1'b1;
    w = 0;
    while (!pkt_rdy_o && w < 20) begin @(negedge clk_i); w++; end
    @(negedge clk_i);
    pkt_vld_i = 1'b0;
    g_req = rs1_req_o; g_idx = rs1_idx_o; g_held = 1'b1;
    if (rs1_req_o) begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clk_i);
        if (rs1_req_o !== 1'b1 || rs1_idx_o !== g_idx) g_held = 1'b0;
      end
      rs1_ack_i = 1'b1; rs1_data_i = data;
      @(negedge clk_i);
      rs1_ack_i = 1'b0; rs1_data_i = '0;
    end
    g_lat = 0;
    while (!redir_vld_o && g_lat < 20) begin @(negedge clk_i); g_lat++; end
    g_vld = redir_vld_o; g_taken = redir_taken_o; g_way = redir_way_o; g_typ = redir_typ_o;
    g_tar = redir_tar_o; g_bmask = br_mask_o;
    @(negedge clk_i);
    g_vld_next = redir_vld_o;
    g_cnt = int'(dbg_ras_cnt_o);
    if (!g_vld) begin flush_i = 1'b1; @(negedge clk_i); flush_i = 1'b0; end
  endtask

  task automatic check_pkt(input string tag, input logic e_taken, input logic [2:0] e_way,
                           input logic [1:0] e_typ, input logic [63:0] e_tar, input logic [7:0] e_bmask,
                           input logic e_req, input logic [4:0] e_idx, input int e_cnt);
    chk({tag, "_vld"}, g_vld, 1);
    chk({tag, "_lat"}, g_lat, 0);
    chk({tag, "_taken"}, g_taken, e_taken);
    if (e_taken) begin
      chk({tag, "_way"}, g_way, e_way);
      chk({tag, "_typ"}, g_typ, e_typ);
    end
    chk({tag, "_tar"}, g_tar, e_tar);
    chk({tag, "_bmask"}, g_bmask, e_bmask);
    chk({tag, "_pulse"}, g_vld_next, 0);
    chk({tag, "_req"}, g_req, e_req);
    if (e_req) begin
      chk({tag, "_idx"}, g_idx, e_idx);
      chk({tag, "_held"}, g_held, 1);
    end
    chk({tag, "_cnt"}, 64'(g_cnt), 64'(e_cnt));
  endtask

  typedef struct {
    logic [63:0]  pc;
    logic [255:0] inst;
    logic [7:0]   mask;
    logic [63:0]  data;
    int           dly;
    logic         e_taken;
    logic [2:0]   e_way;
    logic [1:0]   e_typ;
    logic [63:0]  e_tar;
    logic [7:0]   e_bmask;
    logic [4:0]   e_idx;
    int           e_cnt;
  } vec_t;

  function automatic vec_t mkvec(input logic [63:0] pc, input logic [255:0] inst, input logic [7:0] mask,
                                 input logic [63:0] data, input int dly, input logic t, input logic [2:0] way,
                                 input logic [1:0] typ, input logic [63:0] tar, input logic [7:0] bm,
                                 input logic [4:0] idx, input int cnt);
    vec_t v;
    v.pc = pc; v.inst = inst; v.mask = mask; v.data = data; v.dly = dly;
    v.e_taken = t; v.e_way = way; v.e_typ = typ; v.e_tar = tar; v.e_bmask = bm;
    v.e_idx = idx; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [4:0]  regs[5];
    r = $urandom;
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd7; regs[4] = r[31:27];
    case ($urandom_range(0, 9))
      0, 1:    return NOP;
      2, 3:    return enc_b(r[2:0], r[7:3], r[12:8], {r[24:13], 1'b0});
      4:       return enc_jal(regs[$urandom_range(0, 4)], {r[19:0], 1'b0});
      5:       return enc_jalr(regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)], r[11:0]);
      6:       return enc_jalr(5'd0, ($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5, 12'd0);
      7:       return URET;
      8:       return enc_jal(5'd1, {r[19:0], 1'b0});
      default: return r;
    endcase
  endfunction

  vec_t        vecs[7];
  logic [255:0] ins;
  logic [63:0] r64, pc, data;
  logic [7:0]  mask;
  int          dly;

  initial begin
    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_rdy", pkt_rdy_o, 1);
    chk("rst_req", rs1_req_o, 0);
    chk("rst_idx", rs1_idx_o, 0);
    chk("rst_vld", redir_vld_o, 0);
    chk("rst_taken", redir_taken_o, 0);
    chk("rst_tar", redir_tar_o, 0);
    chk("rst_bmask", br_mask_o, 0);
    chk("rst_cnt", dbg_ras_cnt_o, 0);
    rst_ni = 1'b1;

    // directed vectors
    ins = {NWAY{NOP}}; ins[64 +: 32] = enc_b(3'b000, 5'd1, 5'd2, 13'd16);
    vecs[0] = mkvec(64'h1000, ins, 8'hFF, 0, 0, 0, 0, 0, 64'h1020, 8'h04, 0, 0);
    ins = {NWAY{NOP}}; ins[96 +: 32] = enc_b(3'b001, 5'd3, 5'd4, 13'h1FF8); ins[160 +: 32] = enc_jal(5'd0, 21'h20);
    vecs[1] = mkvec(64'h1000, ins, 8'hFF, 0, 0, 1, 3, 0, 64'h1004, 8'h28, 0, 0);
    ins = {NWAY{NOP}}; ins[64 +: 32] = enc_jal(5'd1, 21'h100);
    vecs[2] = mkvec(64'h2000, ins, 8'hFF, 0, 0, 1, 2, 1, 64'h2108, 8'h04, 0, 1);
    ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jalr(5'd0, 5'd1, 12'd0);
    vecs[3] = mkvec(64'h3000, ins, 8'hFF, 0, 0, 1, 0, 3, 64'h200C, 8'h01, 0, 0);
    ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jalr(5'd0, 5'd7, 12'd8);
    vecs[4] = mkvec(64'h5000, ins, 8'hFF, 64'h4001, 3, 1, 0, 2, 64'h4008, 8'h01, 5'd7, 0);
    ins = {NWAY{NOP}}; ins[32 +: 32] = enc_jal(5'd1, 21'h40); ins[128 +: 32] = enc_b(3'b101, 5'd2, 5'd3, 13'h1FFC);
    vecs[5] = mkvec(64'h8000, ins, 8'hFD, 0, 0, 1, 4, 0, 64'h800C, 8'h10, 0, 0);
    ins = {NWAY{NOP}}; ins[192 +: 32] = URET;
    vecs[6] = mkvec(64'h9000, ins, 8'hFF, 0, 0, 1, 6, 3, 64'h0, 8'h40, 0, 0);

    for (int i = 0; i < 7; i++) begin
      model_pkt(vecs[i].pc, vecs[i].inst, vecs[i].mask, vecs[i].data);
      run_pkt(vecs[i].pc, vecs[i].inst, vecs[i].mask, vecs[i].data, vecs[i].dly);
      check_pkt($sformatf("vec%0d", i), vecs[i].e_taken, vecs[i].e_way, vecs[i].e_typ, vecs[i].e_tar,
                vecs[i].e_bmask, vecs[i].e_taken && vecs[i].e_typ == 2'd2, vecs[i].e_idx, vecs[i].e_cnt);
    end

    // RAS overflow then underflow
    for (int k = 0; k <= RAS_DEPTH; k++) begin
      ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jal(5'd1, 21'h40);
      pc = 64'h10000 + 64'(k * 256);
      model_pkt(pc, ins, 8'h01, 0);
      run_pkt(pc, ins, 8'h01, 0, 0);
      chk($sformatf("call%0d_tar", k), g_tar, pc + 64'h40);
      chk($sformatf("call%0d_cnt", k), 64'(g_cnt), 64'((k + 1 > RAS_DEPTH) ? RAS_DEPTH : k + 1));
    end
    for (int j = 0; j <= RAS_DEPTH; j++) begin
      ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jalr(5'd0, 5'd1, 12'd0);
      model_pkt(64'h20000, ins, 8'h01, 0);
      run_pkt(64'h20000, ins, 8'h01, 0, 0);
      chk($sformatf("ret%0d_tar", j), g_tar,
          (j < RAS_DEPTH) ? 64'h10000 + 64'((RAS_DEPTH - j) * 256) + 64'h4 : 64'h0);
      chk($sformatf("ret%0d_typ", j), g_typ, 2'd3);
      chk($sformatf("ret%0d_cnt", j), 64'(g_cnt), 64'((j < RAS_DEPTH) ? RAS_DEPTH - 1 - j : 0));
    end

    // flush while waiting for rs1; the late ack must be ignored
    ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jalr(5'd0, 5'd7, 12'd8);
    @(negedge clk_i);
    pkt_pc_i = 64'h6000; pkt_inst_i = ins; pkt_mask_i = 8'hFF; pkt_vld_i = 1'b1;
    @(negedge clk_i);
    pkt_vld_i = 1'b0;
    chk("fl_req", rs1_req_o, 1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; rs1_ack_i = 1'b1; rs1_data_i = 64'h4001;
    #1;
    chk("fl_rdy", pkt_rdy_o, 1);
    chk("fl_req_drop", rs1_req_o, 0);
    chk("fl_vld", redir_vld_o, 0);
    @(negedge clk_i);
    rs1_ack_i = 1'b0;
    chk("fl_vld_late", redir_vld_o, 0);
    chk("fl_state", dbg_state_o, 0);

    // a packet offered together with flush is not taken
    ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jal(5'd1, 21'h40);
    pkt_pc_i = 64'h6100; pkt_inst_i = ins; pkt_vld_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("fl_rdy_gate", pkt_rdy_o, 0);
    @(negedge clk_i);
    pkt_vld_i = 1'b0; flush_i = 1'b0;
    chk("fl_noacc_vld", redir_vld_o, 0);
    chk("fl_noacc_state", dbg_state_o, 0);
    chk("fl_noacc_cnt", dbg_ras_cnt_o, 64'(ras_q.size()));

    // random packets against the model
    for (int n = 0; n < 250; n++) begin
      ins = '0;
      for (int l = 0; l < NWAY; l++) ins[32*l +: 32] = rand_inst();
      r64 = {$urandom, $urandom};
      pc = ($urandom_range(0, 3) == 0) ? {r64[63:2], 2'b00} : {48'd0, r64[15:2], 2'b00};
      mask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 255));
      data = {$urandom, $urandom};
      dly = $urandom_range(0, 3);
      model_pkt(pc, ins, mask, data);
      run_pkt(pc, ins, mask, data, dly);
      check_pkt($sformatf("rnd%0d", n), m_taken, m_way, m_typ, m_tar, m_bmask, m_req, m_idx, ras_q.size());
    end

    // async reset in the middle of RESP, with a push pending
    ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jal(5'd5, 21'h80);
    @(negedge clk_i);
    pkt_pc_i = 64'h7000; pkt_inst_i = ins; pkt_mask_i = 8'hFF; pkt_vld_i = 1'b1;
    @(negedge clk_i);
    pkt_vld_i = 1'b0;
    chk("rr_vld_before", redir_vld_o, 1);
    rst_ni = 1'b0;
    #1;
    ras_q.delete();
    chk("rr_vld", redir_vld_o, 0);
    chk("rr_taken", redir_taken_o, 0);
    chk("rr_tar", redir_tar_o, 0);
    chk("rr_bmask", br_mask_o, 0);
    chk("rr_rdy", pkt_rdy_o, 1);
    chk("rr_cnt", dbg_ras_cnt_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // stack must really be empty: a return yields 0
    ins = {NWAY{NOP}}; ins[0 +: 32] = enc_jalr(5'd0, 5'd5, 12'd0);
    model_pkt(64'h7100, ins, 8'h01, 0);
    run_pkt(64'h7100, ins, 8'h01, 0, 0);
    check_pkt("rr_ret", 1, 0, 3, 64'h0, 8'h01, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
